// File: rtl/prince_ti_sbox_compress.sv
// Share compression stage after the PRINCE TI S-box slices: glitch-barrier register, then 8->2 share XOR compression.
// Optional PRINCE_TI_REMASK_EN adds rand_i, which remasks both output shares at the S2 load.
module prince_ti_sbox_compress (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] sh_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [3:0]  out1_o,
  output logic [3:0]  out2_o,
  output logic        valid_o,
`ifdef PRINCE_TI_REMASK_EN
  input  logic [3:0]  rand_i,
`endif
  input  logic        ready_i
);

  localparam int unsigned NB     = 4;
  localparam int unsigned NSH_IN = 8;
  localparam int unsigned NHALF  = NSH_IN / 2;

  logic [NB*NSH_IN-1:0] r_s1;
  logic                 r_s1_v;
  logic [NB-1:0]        r_out1;
  logic [NB-1:0]        r_out2;
  logic                 r_s2_v;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic [NB-1:0]        w_c1;
  logic [NB-1:0]        w_c2;

  assign w_s2_adv = !r_s2_v || ready_i;
  assign w_s1_adv = !r_s1_v || w_s2_adv;

  // Each tree reads only the shares of its own bit, so slices never mix.
  always_comb begin
    w_c1 = '0;
    w_c2 = '0;
    for (int b = 0; b < int'(NB); b++) begin
      w_c1[b] = ^r_s1[NSH_IN*b +: NHALF];
      w_c2[b] = ^r_s1[NSH_IN*b + NHALF +: NHALF];
    end
`ifdef PRINCE_TI_REMASK_EN
    w_c1 = w_c1 ^ rand_i;
    w_c2 = w_c2 ^ rand_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1   <= '0;
      r_s1_v <= 1'b0;
      r_out1 <= '0;
      r_out2 <= '0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= valid_i;
      end
      // S1 is a pure register: no logic between sh_i and r_s1.
      if (w_s1_adv && valid_i) begin
        r_s1 <= sh_i;
      end
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
      end
      if (w_s2_adv && r_s1_v) begin
        r_out1 <= w_c1;
        r_out2 <= w_c2;
      end
    end
  end

  assign ready_o = w_s1_adv;
  assign out1_o  = r_out1;
  assign out2_o  = r_out2;
  assign valid_o = r_s2_v;

endmodule

// File: tb/tb_prince_ti_sbox_compress.sv
// Scoreboard bench for prince_ti_sbox_compress; build with +define+PRINCE_TI_REMASK_EN for the remask variant.
module tb_prince_ti_sbox_compress;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] sh_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  out1_o;
  logic [3:0]  out2_o;
  logic        valid_o;
  logic        ready_i;
`ifdef PRINCE_TI_REMASK_EN
  logic [3:0]  rand_i;
`endif

  typedef struct packed {
    logic [3:0] c1;
    logic [3:0] c2;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] rmask    = 4'h0;
  bit         xor_only = 1'b0;
  bit         rnd_mask = 1'b0;

  prince_ti_sbox_compress dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .sh_i    (sh_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .out1_o  (out1_o),
    .out2_o  (out2_o),
    .valid_o (valid_o),
`ifdef PRINCE_TI_REMASK_EN
    .rand_i  (rand_i),
`endif
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t model(input logic [31:0] sh);
    exp_t e;
    e = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        if (k < 4) e.c1[b] = e.c1[b] ^ sh[8*b+k];
        else       e.c2[b] = e.c2[b] ^ sh[8*b+k];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then score the handshakes that the next rising edge will complete.
  task automatic step(input logic [31:0] sh, input logic v, input logic rdy);
    exp_t e;
    @(negedge clk_i);
    sh_i    = sh;
    valid_i = v;
    ready_i = rdy;
`ifdef PRINCE_TI_REMASK_EN
    rand_i  = rnd_mask ? 4'($urandom_range(0, 15)) : rmask;
`endif
    #1;
    if (valid_i === 1'b1 && ready_o === 1'b1) q.push_back(model(sh_i));
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 4'(valid_o), 4'h0);
      end else begin
        e = q.pop_front();
        if (xor_only) begin
          chk("unmasked", out1_o ^ out2_o, e.c1 ^ e.c2);
        end else begin
          chk("out1", out1_o, e.c1 ^ rmask);
          chk("out2", out2_o, e.c2 ^ rmask);
        end
      end
    end
  endtask

  initial begin
`ifdef PRINCE_TI_REMASK_EN
    rmask  = 4'hF;
    rand_i = rmask;
`endif
    rst_ni  = 1'b0;
    sh_i    = '0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    #12;
    chk("rst_valid_o", 4'(valid_o), 4'h0);
    chk("rst_ready_o", 4'(ready_o), 4'h1);
    chk("rst_out1", out1_o, 4'h0);
    chk("rst_out2", out2_o, 4'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle after reset: nothing emerges, block stays ready.
    for (int i = 0; i < 4; i++) begin
      step(32'($urandom), 1'b0, 1'b1);
      chk("idle_valid_o", 4'(valid_o), 4'h0);
      chk("idle_ready_o", 4'(ready_o), 4'h1);
    end

    // Single set, two-cycle latency, one-cycle valid pulse.
    step(32'h0000_0001, 1'b1, 1'b1);
    step(32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("lat_valid_t1", 4'(valid_o), 4'h0);
    step(32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("lat_valid_t2", 4'(valid_o), 4'h1);
    step(32'h0, 1'b0, 1'b1);
    chk("lat_valid_t3", 4'(valid_o), 4'h0);

    // Back-to-back sets emerge on consecutive cycles.
    step(32'h8000_0000, 1'b1, 1'b1);
    step(32'h0F0F_0F0F, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b1);
    chk("b2b_valid_1", 4'(valid_o), 4'h1);
    step(32'h0, 1'b0, 1'b1);
    chk("b2b_valid_2", 4'(valid_o), 4'h1);
    step(32'h0, 1'b0, 1'b1);
    chk("b2b_valid_3", 4'(valid_o), 4'h0);

    // Backpressure: two sets fill the pipe, third waits until ready_i returns.
    step(32'h0000_0100, 1'b1, 1'b0);
    step(32'h0010_0000, 1'b1, 1'b0);
    step(32'h8000_0001, 1'b1, 1'b0);
    chk("bp_ready_o", 4'(ready_o), 4'h0);
    chk("bp_out1_hold", out1_o, 4'h2 ^ rmask);
    chk("bp_out2_hold", out2_o, 4'h0 ^ rmask);
    step(32'h8000_0001, 1'b1, 1'b0);
    chk("bp_ready_o_2", 4'(ready_o), 4'h0);
    chk("bp_valid_hold", 4'(valid_o), 4'h1);
    chk("bp_out1_hold2", out1_o, 4'h2 ^ rmask);
    step(32'h8000_0001, 1'b1, 1'b1);
    chk("bp_ready_release", 4'(ready_o), 4'h1);
    for (int i = 0; i < 4; i++) step(32'h0, 1'b0, 1'b1);
    chk("bp_queue_empty", 4'(q.size()), 4'h0);

    // Async reset with both stages full: outputs clear without a clock edge.
    step(32'h0000_0001, 1'b1, 1'b0);
    step(32'h0000_0010, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("full_valid_o", 4'(valid_o), 4'h1);
    chk("full_ready_o", 4'(ready_o), 4'h0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid_o", 4'(valid_o), 4'h0);
    chk("arst_out1", out1_o, 4'h0);
    chk("arst_out2", out2_o, 4'h0);
    chk("arst_ready_o", 4'(ready_o), 4'h1);
    q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(32'h0000_0001, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b1);
    chk("post_rst_t1", 4'(valid_o), 4'h0);
    step(32'h0, 1'b0, 1'b1);
    chk("post_rst_t2", 4'(valid_o), 4'h1);
    step(32'h0, 1'b0, 1'b1);

    // Random sweep with random valid/ready; remask build varies rand_i and checks the unmasked value.
`ifdef PRINCE_TI_REMASK_EN
    xor_only = 1'b1;
    rnd_mask = 1'b1;
`endif
    for (int i = 0; i < 300; i++)
      step(32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 6; i++) step(32'h0, 1'b0, 1'b1);
    chk("final_queue_empty", 4'(q.size()), 4'h0);
    chk("final_valid_o", 4'(valid_o), 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
